// File: rtl/tetris_pkg.sv
// Shared constants for the playfield blocks: main FSM state codes, board
// geometry defaults, piece type codes, spawn anchor and the piece
// controller's own state/move encodings.
package tetris_pkg;

  // Main game FSM state codes, as driven on piece_ctrl.state
  localparam logic [2:0] ST_GEN      = 3'b000;
  localparam logic [2:0] ST_MOVE     = 3'b001;
  localparam logic [2:0] ST_LAND     = 3'b010;
  localparam logic [2:0] ST_NEWBOARD = 3'b100;
  localparam logic [2:0] ST_GAMEOVER = 3'b101;

  localparam int BOARD_W_DEF = 10;
  localparam int BOARD_H_DEF = 20;
  localparam int SPAWN_X_DEF = 3;
  localparam int SPAWN_Y_DEF = 0;

  // Piece type codes
  localparam logic [2:0] T_I = 3'd0;
  localparam logic [2:0] T_O = 3'd1;
  localparam logic [2:0] T_T = 3'd2;
  localparam logic [2:0] T_S = 3'd3;
  localparam logic [2:0] T_Z = 3'd4;
  localparam logic [2:0] T_J = 3'd5;
  localparam logic [2:0] T_L = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE, S_READY, S_CHK, S_LOCK, S_SPAWN_CHK, S_DONE
  } pc_state_t;

  typedef enum logic [1:0] {
    MV_DOWN, MV_ROT, MV_LEFT, MV_RIGHT
  } move_t;

  // Code 7 is not a piece; fold it onto type 0
  function automatic logic [2:0] norm_type(input logic [2:0] t);
    return (t == 3'd7) ? T_I : t;
  endfunction

endpackage

// File: rtl/gravity_timer.sv
// Gravity step timer.
//  clka    in  system clock
//  restart in  async active-high reset
//  en      in  count enable
//  clr     in  synchronous clear (new piece)
//  tick    out 1-cycle pulse on the terminal count, counter wraps to 0
module gravity_timer #(
  parameter int GRAVITY_CYCLES = 5_000_000
) (
  input  logic clka,
  input  logic restart,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (GRAVITY_CYCLES > 2) ? $clog2(GRAVITY_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(GRAVITY_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Combinational so the consumer can serve the step on the wrap edge itself
  assign tick = en && (cnt == TERM);

  always_ff @(posedge clka or posedge restart) begin
    if (restart)   cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/piece_ctrl.sv
// Active-piece controller. Tracks the main FSM state, moves the falling
// piece through collision queries to board memory, commits landed pieces
// and reports placed/game_over back to the main FSM.
//  clka, restart                 clock, async active-high reset
//  state[2:0]                    main FSM state code
//  btn_left/right/rot/drop       1-cycle move requests
//  next_type[2:0]                upcoming piece type
//  chk_req/x/y/rot/type, chk_ack, chk_hit   collision query handshake
//  lock_req, lock_ack            commit-to-board handshake
//  piece_x/y/rot/type            active piece for rendering
//  placed, game_over             landing result to the main FSM
module piece_ctrl
  import tetris_pkg::*;
#(
  parameter int BOARD_W        = BOARD_W_DEF,
  parameter int GRAVITY_CYCLES = 5_000_000,
  parameter int SPAWN_X        = SPAWN_X_DEF,
  parameter int SPAWN_Y        = SPAWN_Y_DEF
) (
  input  logic       clka,
  input  logic       restart,
  input  logic [2:0] state,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_rot,
  input  logic       btn_drop,
  input  logic [2:0] next_type,
  output logic       chk_req,
  output logic [4:0] chk_x,
  output logic [4:0] chk_y,
  output logic [1:0] chk_rot,
  output logic [2:0] chk_type,
  input  logic       chk_ack,
  input  logic       chk_hit,
  output logic       lock_req,
  input  logic       lock_ack,
  output logic [4:0] piece_x,
  output logic [4:0] piece_y,
  output logic [1:0] piece_rot,
  output logic [2:0] piece_type,
  output logic       placed,
  output logic       game_over
);

  localparam logic [4:0] X_MIN = 5'b11110;          // -2
  localparam logic [4:0] X_MAX = 5'(BOARD_W - 1);
  localparam logic [4:0] SX    = 5'(SPAWN_X);
  localparam logic [4:0] SY    = 5'(SPAWN_Y);

  pc_state_t fsm, fsm_nxt;
  move_t     mv;
  logic      issue, spawn, grav_now, grav_tick, tmr_en;
  logic      abort_state, abort_now;
  logic      grav_pend, drop_act, cur_down, aborted;

  assign abort_state = (state == ST_NEWBOARD) || (state == ST_GAMEOVER);
  // Abort seen at any point while a handshake is open discards its result
  assign abort_now   = aborted || abort_state;
  assign tmr_en      = ((fsm == S_READY) || (fsm == S_CHK)) && (state == ST_MOVE);
  assign grav_now    = grav_pend || grav_tick;

  gravity_timer #(.GRAVITY_CYCLES(GRAVITY_CYCLES)) u_grav (
    .clka    (clka),
    .restart (restart),
    .en      (tmr_en),
    .clr     (spawn),
    .tick    (grav_tick)
  );

  always_ff @(posedge clka or posedge restart) begin
    if (restart) fsm <= S_IDLE;
    else         fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    issue   = 1'b0;
    mv      = MV_DOWN;
    spawn   = 1'b0;
    case (fsm)
      S_IDLE:
        if (state == ST_GEN) begin
          spawn   = 1'b1;
          fsm_nxt = S_READY;
        end
      S_READY:
        if (abort_state) fsm_nxt = S_IDLE;
        else if (state == ST_MOVE) begin
          // A drop in progress keeps priority until it lands
          if (drop_act || btn_drop)                     begin issue = 1'b1; mv = MV_DOWN;  end
          else if (grav_now)                            begin issue = 1'b1; mv = MV_DOWN;  end
          else if (btn_rot)                             begin issue = 1'b1; mv = MV_ROT;   end
          else if (btn_left  && (piece_x != X_MIN))     begin issue = 1'b1; mv = MV_LEFT;  end
          else if (btn_right && (piece_x != X_MAX))     begin issue = 1'b1; mv = MV_RIGHT; end
          if (issue) fsm_nxt = S_CHK;
        end
      S_CHK:
        if (chk_ack) begin
          if (abort_now)                fsm_nxt = S_IDLE;
          else if (chk_hit && cur_down) fsm_nxt = S_LOCK;
          else                          fsm_nxt = S_READY;
        end
      S_LOCK:
        if (lock_ack) fsm_nxt = abort_now ? S_IDLE : S_SPAWN_CHK;
      S_SPAWN_CHK:
        if (chk_ack) fsm_nxt = abort_now ? S_IDLE : S_DONE;
      S_DONE:
        if (placed && (state != ST_MOVE)) fsm_nxt = S_IDLE;
      default: fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      piece_x    <= SX;
      piece_y    <= SY;
      piece_rot  <= 2'd0;
      piece_type <= T_I;
      chk_req    <= 1'b0;
      chk_x      <= SX;
      chk_y      <= SY;
      chk_rot    <= 2'd0;
      chk_type   <= T_I;
      lock_req   <= 1'b0;
      placed     <= 1'b0;
      game_over  <= 1'b0;
      grav_pend  <= 1'b0;
      drop_act   <= 1'b0;
      cur_down   <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      if (spawn) begin
        piece_type <= norm_type(next_type);
        piece_x    <= SX;
        piece_y    <= SY;
        piece_rot  <= 2'd0;
      end

      // Any down check (gravity or drop) serves a pending gravity step
      grav_pend <= (grav_pend || grav_tick) && !((issue && (mv == MV_DOWN)) || spawn);

      if (issue) begin
        chk_req  <= 1'b1;
        chk_type <= piece_type;
        chk_x    <= piece_x;
        chk_y    <= piece_y;
        chk_rot  <= piece_rot;
        cur_down <= (mv == MV_DOWN);
        case (mv)
          MV_DOWN:  chk_y   <= piece_y + 5'd1;
          MV_ROT:   chk_rot <= piece_rot + 2'd1;
          MV_LEFT:  chk_x   <= piece_x - 5'd1;
          MV_RIGHT: chk_x   <= piece_x + 5'd1;
        endcase
        if (btn_drop) drop_act <= 1'b1;
      end

      if ((fsm == S_CHK) && chk_ack) begin
        chk_req <= 1'b0;
        if (!abort_now) begin
          if (!chk_hit) begin
            piece_x   <= chk_x;
            piece_y   <= chk_y;
            piece_rot <= chk_rot;
          end else if (cur_down) begin
            lock_req <= 1'b1;
            drop_act <= 1'b0;
          end
        end
      end

      if ((fsm == S_LOCK) && lock_ack) begin
        lock_req <= 1'b0;
        if (!abort_now) begin
          chk_req  <= 1'b1;
          chk_x    <= SX;
          chk_y    <= SY;
          chk_rot  <= 2'd0;
          chk_type <= norm_type(next_type);
        end
      end

      // game_over lands here, placed one cycle later in DONE
      if ((fsm == S_SPAWN_CHK) && chk_ack) begin
        chk_req <= 1'b0;
        if (!abort_now) game_over <= chk_hit;
      end

      if (fsm == S_DONE) begin
        if (!placed)                placed <= 1'b1;
        else if (state != ST_MOVE)  placed <= 1'b0;
      end

      if (fsm_nxt == S_IDLE) begin
        aborted  <= 1'b0;
        drop_act <= 1'b0;
      end else if (abort_state && ((fsm == S_CHK) || (fsm == S_LOCK) || (fsm == S_SPAWN_CHK))) begin
        aborted <= 1'b1;
      end

      if (state == ST_NEWBOARD) game_over <= 1'b0;
    end
  end

endmodule

// File: tb/tb_piece_ctrl.sv
// Directed bench for piece_ctrl with a small board responder.
module tb_piece_ctrl;
  import tetris_pkg::*;

  logic       clka = 1'b0;
  logic       restart;
  logic [2:0] state;
  logic       btn_left, btn_right, btn_rot, btn_drop;
  logic [2:0] next_type;
  logic       chk_req, chk_ack, chk_hit, lock_req, lock_ack;
  logic [4:0] chk_x, chk_y, piece_x, piece_y;
  logic [1:0] chk_rot, piece_rot;
  logic [2:0] chk_type, piece_type;
  logic       placed, game_over;

  // Board responder controls
  logic resp_en = 1'b1;
  logic a_ack = 1'b0, a_hit = 1'b0, a_lock = 1'b0;
  logic m_ack = 1'b0, m_hit = 1'b0;
  int   floor_y   = 31;
  logic hit_all   = 1'b0;
  logic spawn_hit = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  assign chk_ack  = resp_en ? a_ack : m_ack;
  assign chk_hit  = resp_en ? a_hit : m_hit;
  assign lock_ack = resp_en ? a_lock : 1'b0;

  piece_ctrl #(.GRAVITY_CYCLES(4)) dut (
    .clka(clka), .restart(restart), .state(state),
    .btn_left(btn_left), .btn_right(btn_right), .btn_rot(btn_rot), .btn_drop(btn_drop),
    .next_type(next_type),
    .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y), .chk_rot(chk_rot), .chk_type(chk_type),
    .chk_ack(chk_ack), .chk_hit(chk_hit),
    .lock_req(lock_req), .lock_ack(lock_ack),
    .piece_x(piece_x), .piece_y(piece_y), .piece_rot(piece_rot), .piece_type(piece_type),
    .placed(placed), .game_over(game_over)
  );

  always #5 clka = ~clka;

  function automatic logic board_hit(input logic [4:0] x, input logic [4:0] y, input logic [1:0] r);
    return hit_all || (int'(y) >= floor_y) ||
           (spawn_hit && (x == 5'd3) && (y == 5'd0) && (r == 2'd0));
  endfunction

  // Zero-latency responder: acks whatever request it sees at a falling edge
  initial begin
    forever begin
      @(negedge clka);
      a_ack = 1'b0; a_hit = 1'b0; a_lock = 1'b0;
      if (chk_req) begin
        a_ack = 1'b1;
        a_hit = board_hit(chk_x, chk_y, chk_rot);
      end
      if (lock_req) a_lock = 1'b1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic l, input logic r, input logic ro,
                       output logic saw_req, output logic [4:0] saw_x);
    state = ST_MOVE; btn_left = l; btn_right = r; btn_rot = ro;
    @(negedge clka);
    btn_left = 1'b0; btn_right = 1'b0; btn_rot = 1'b0; state = ST_LAND;
    saw_req = chk_req; saw_x = chk_x;
    repeat (2) @(negedge clka);
  endtask

  task automatic respawn(input logic [2:0] t);
    state = ST_NEWBOARD;
    @(negedge clka);
    state = ST_GEN; next_type = t;
    @(negedge clka);
    state = ST_LAND;
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_x"},    piece_x,    5'd3);
    chk({pfx, "_y"},    piece_y,    5'd0);
    chk({pfx, "_rot"},  piece_rot,  2'd0);
    chk({pfx, "_type"}, piece_type, 3'd0);
    chk({pfx, "_creq"}, chk_req,    1'b0);
    chk({pfx, "_lreq"}, lock_req,   1'b0);
    chk({pfx, "_plc"},  placed,     1'b0);
    chk({pfx, "_go"},   game_over,  1'b0);
  endtask

  initial begin
    logic       sr;
    logic [4:0] sx;
    int         nq, bad;
    logic       prev, done;

    restart = 1'b1; state = ST_NEWBOARD; next_type = 3'd0;
    btn_left = 0; btn_right = 0; btn_rot = 0; btn_drop = 0;
    repeat (3) @(negedge clka);
    check_reset_vals("rst");
    restart = 1'b0;
    @(negedge clka);

    // Spawn
    state = ST_GEN; next_type = 3'd3;
    @(negedge clka);
    chk("spawn_type", piece_type, 3'd3);
    chk("spawn_x",    piece_x,    5'd3);
    chk("spawn_y",    piece_y,    5'd0);
    chk("spawn_rot",  piece_rot,  2'd0);
    chk("spawn_creq", chk_req,    1'b0);
    chk("spawn_lreq", lock_req,   1'b0);

    // Gravity: first down query on the 4th edge with MOVE
    state = ST_MOVE;
    repeat (3) @(negedge clka);
    chk("grav_early", chk_req, 1'b0);
    @(negedge clka);
    chk("grav_req",  chk_req, 1'b1);
    chk("grav_chky", chk_y,   5'd1);
    @(negedge clka);
    state = ST_LAND;
    chk("grav_y", piece_y, 5'd1);

    // Wall: walk left to -2 (gravity steps absorbed on known cycles)
    respawn(3'd1);
    press(1, 0, 0, sr, sx);
    press(1, 0, 0, sr, sx);
    press(1, 0, 0, sr, sx);
    chk("wall_x0", piece_x, 5'd0);
    press(0, 0, 0, sr, sx);
    chk("wall_gy", piece_y, 5'd1);
    press(1, 0, 0, sr, sx);
    press(1, 0, 0, sr, sx);
    chk("wall_xm2", piece_x, 5'b11110);
    press(1, 0, 0, sr, sx);
    chk("wall_noreq", sr,      1'b0);
    chk("wall_hold",  piece_x, 5'b11110);
    press(0, 0, 0, sr, sx);
    chk("wall_gy2", piece_y, 5'd2);
    hit_all = 1'b1;
    press(0, 1, 0, sr, sx);
    chk("right_req",  sr,       1'b1);
    chk("right_chkx", sx,       5'b11111);
    chk("right_x",    piece_x,  5'b11110);
    chk("right_lock", lock_req, 1'b0);
    hit_all = 1'b0;

    // Drop onto floor at 17
    respawn(3'd5);
    chk("drop_type", piece_type, 3'd5);
    floor_y = 17; next_type = 3'd2;
    state = ST_MOVE; btn_drop = 1'b1;
    nq = 0; bad = 0; prev = 1'b0; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clka);
      btn_drop = 1'b0;
      if (chk_req && !prev) begin
        nq++;
        if (chk_y != 5'(nq)) bad++;
      end
      prev = chk_req;
      if (lock_req) done = 1'b1;
    end
    chk("drop_lock",   lock_req, 1'b1);
    chk("drop_nq",     nq,       32'd17);
    chk("drop_seq",    bad,      32'd0);
    chk("drop_y",      piece_y,  5'd16);
    chk("drop_excl",   chk_req,  1'b0);
    @(negedge clka);
    chk("sp_req",  chk_req,  1'b1);
    chk("sp_lock", lock_req, 1'b0);
    chk("sp_x",    chk_x,    5'd3);
    chk("sp_y",    chk_y,    5'd0);
    chk("sp_type", chk_type, 3'd2);
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clka);
      if (placed) done = 1'b1;
    end
    chk("drop_placed", placed,    1'b1);
    chk("drop_go",     game_over, 1'b0);
    state = ST_LAND;
    @(negedge clka);
    chk("placed_fall", placed, 1'b0);

    // Game over: spawn check hits
    state = ST_GEN;
    @(negedge clka);
    chk("go_spawn_type", piece_type, 3'd2);
    spawn_hit = 1'b1;
    state = ST_MOVE; btn_drop = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clka);
      btn_drop = 1'b0;
      if (game_over) done = 1'b1;
    end
    chk("go_set",    game_over, 1'b1);
    chk("go_before", placed,    1'b0);
    @(negedge clka);
    chk("go_placed", placed,    1'b1);
    state = ST_GAMEOVER;
    repeat (3) @(negedge clka);
    chk("go_sticky", game_over, 1'b1);
    chk("go_plc0",   placed,    1'b0);
    state = ST_NEWBOARD;
    @(negedge clka);
    chk("go_clear",  game_over, 1'b0);
    spawn_hit = 1'b0;

    // Abort: rotation query outstanding when GAMEOVER arrives
    resp_en = 1'b0;
    state = ST_GEN; next_type = 3'd7;
    @(negedge clka);
    chk("ab_type7", piece_type, 3'd0);
    state = ST_MOVE; btn_rot = 1'b1;
    @(negedge clka);
    btn_rot = 1'b0;
    chk("ab_req",  chk_req, 1'b1);
    chk("ab_crot", chk_rot, 2'd1);
    state = ST_GAMEOVER;
    repeat (3) @(negedge clka);
    chk("ab_held", chk_req, 1'b1);
    m_ack = 1'b1; m_hit = 1'b0;
    @(negedge clka);
    m_ack = 1'b0;
    chk("ab_drop", chk_req,   1'b0);
    chk("ab_rot",  piece_rot, 2'd0);
    chk("ab_x",    piece_x,   5'd3);
    next_type = 3'd4; state = ST_GEN;
    @(negedge clka);
    chk("ab_idle", piece_type, 3'd4);
    resp_en = 1'b1;

    // Restart mid-drop
    state = ST_MOVE; btn_drop = 1'b1;
    @(negedge clka);
    btn_drop = 1'b0;
    repeat (6) @(negedge clka);
    chk("rs_moved", piece_y, 5'd3);
    #2 restart = 1'b1;
    #1 check_reset_vals("rs");
    @(negedge clka);
    restart = 1'b0; state = ST_NEWBOARD;
    @(negedge clka);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
